// File: rtl/id_ex_stage_seq_if.sv
// ID/EX stage bundle: decoded control and operands in, registered EX-stage fields out,
// plus the SORT sequencing handshake with the control unit and hazard logic.
interface id_ex_stage_seq_if #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 4
);
  logic              freeze;
  logic              flush;
  logic              wb_en_in;
  logic              mem_r_en_in;
  logic              mem_w_en_in;
  logic              b_in;
  logic              s_in;
  logic [3:0]        exe_cmd_in;
  logic              is_sort_in;
  logic [WORD_W-1:0] pc_in;
  logic [WORD_W-1:0] val_rn_in;
  logic [WORD_W-1:0] val_rm_in;
  logic              imm_in;
  logic [11:0]       shift_operand_in;
  logic [23:0]       signed_imm_24_in;
  logic [REG_W-1:0]  dest_in;
  logic [REG_W-1:0]  src2_in;
  logic [3:0]        status_in;

  logic              sort_cycle_count;
  logic              sort_stall;
  logic              wb_en;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              b;
  logic              s;
  logic [3:0]        exe_cmd;
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] val_rn;
  logic [WORD_W-1:0] val_rm;
  logic              imm;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [REG_W-1:0]  dest;
  logic [3:0]        status;

  modport master (
    output freeze, flush, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
           is_sort_in, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
           signed_imm_24_in, dest_in, src2_in, status_in,
    input  sort_cycle_count, sort_stall, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd,
           pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, status
  );

  modport slave (
    input  freeze, flush, wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, exe_cmd_in,
           is_sort_in, pc_in, val_rn_in, val_rm_in, imm_in, shift_operand_in,
           signed_imm_24_in, dest_in, src2_in, status_in,
    output sort_cycle_count, sort_stall, wb_en, mem_r_en, mem_w_en, b, s, exe_cmd,
           pc, val_rn, val_rm, imm, shift_operand, signed_imm_24, dest, status
  );
endinterface

// File: rtl/id_ex_stage_seq.sv
// ID->EX pipeline register with flush/freeze and the two-cycle SORT sequencer.
// SORT sequencing is built only when SORT_SEQ_EN is defined; otherwise a plain pipeline register.
//
// state | meaning
// IDLE  | normal issue; a SORT in ID here is micro-op 0 and stalls IF/ID one cycle
// SORT2 | second SORT micro-op in ID; dest takes Rm
module id_ex_stage_seq #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 4
) (
  input logic               clk,
  input logic               rst,
  id_ex_stage_seq_if.slave  bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SORT2 = 1'b1;

  logic [REG_W-1:0] dest_next;

`ifdef SORT_SEQ_EN
  logic [0:0] state;
  logic       in_sort2;

  assign in_sort2 = (state == ST_SORT2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (!bus.freeze) begin
      if (bus.flush)
        state <= ST_IDLE;
      else if (state == ST_IDLE && bus.is_sort_in)
        state <= ST_SORT2;
      else
        state <= ST_IDLE;
    end
  end

  assign bus.sort_cycle_count = in_sort2;
  // Combinational so the SORT is held in ID for its second micro-op.
  assign bus.sort_stall       = bus.is_sort_in & ~in_sort2 & ~bus.flush;
  assign dest_next            = in_sort2 ? bus.src2_in : bus.dest_in;
`else
  logic sort_unused;

  assign sort_unused          = ^{bus.is_sort_in, bus.src2_in, ST_IDLE, ST_SORT2};
  assign bus.sort_cycle_count = 1'b0;
  assign bus.sort_stall       = 1'b0;
  assign dest_next            = bus.dest_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_en         <= 1'b0;
      bus.mem_r_en      <= 1'b0;
      bus.mem_w_en      <= 1'b0;
      bus.b             <= 1'b0;
      bus.s             <= 1'b0;
      bus.exe_cmd       <= 4'd0;
      bus.pc            <= '0;
      bus.val_rn        <= '0;
      bus.val_rm        <= '0;
      bus.imm           <= 1'b0;
      bus.shift_operand <= 12'd0;
      bus.signed_imm_24 <= 24'd0;
      bus.dest          <= '0;
      bus.status        <= 4'd0;
    end else if (!bus.freeze) begin
      // A flush only needs to kill the control bundle; data fields are don't-care in a bubble.
      if (bus.flush) begin
        bus.wb_en    <= 1'b0;
        bus.mem_r_en <= 1'b0;
        bus.mem_w_en <= 1'b0;
        bus.b        <= 1'b0;
        bus.s        <= 1'b0;
        bus.exe_cmd  <= 4'd0;
      end else begin
        bus.wb_en    <= bus.wb_en_in;
        bus.mem_r_en <= bus.mem_r_en_in;
        bus.mem_w_en <= bus.mem_w_en_in;
        bus.b        <= bus.b_in;
        bus.s        <= bus.s_in;
        bus.exe_cmd  <= bus.exe_cmd_in;
      end
      bus.pc            <= bus.pc_in;
      bus.val_rn        <= bus.val_rn_in;
      bus.val_rm        <= bus.val_rm_in;
      bus.imm           <= bus.imm_in;
      bus.shift_operand <= bus.shift_operand_in;
      bus.signed_imm_24 <= bus.signed_imm_24_in;
      bus.dest          <= dest_next;
      bus.status        <= bus.status_in;
    end
  end
endmodule

// File: doc/id_ex_stage_seq.md
Name: id_ex_stage_seq

Overview:
- ID→EX pipeline register of the ARM-subset core; sits directly downstream of the decode control unit and register file.
- Latches the control bundle (WB/MEM/B/S/EXE_CMD) and the operand bundle into the EX stage.
- Sequences the two-cycle SORT instruction: drives sort_cycle_count back to the control unit and stalls IF/ID for one cycle.
- Applies branch flush and memory freeze.

Parameters:
- WORD_W, 32, data/PC width
- REG_W, 4, register address width

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- freeze  in  1  hold all state (memory stall)
- flush  in  1  branch taken in EX; insert bubble
- wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in  in  1 each  control-unit outputs
- exe_cmd_in  in  4  control-unit ALU command
- is_sort_in  in  1  decoded SORT (mode 00, opcode 0011, condition passed)
- pc_in  in  WORD_W  PC of instruction in ID
- val_rn_in, val_rm_in  in  WORD_W  register-file read data
- imm_in  in  1  immediate flag
- shift_operand_in  in  12  shifter operand
- signed_imm_24_in  in  24  branch offset
- dest_in, src2_in  in  REG_W  Rd, Rm
- status_in  in  4  NZCV
- sort_cycle_count  out  1  to control unit: 0 = first SORT micro-op, 1 = second
- sort_stall  out  1  to hazard/IF: hold PC and IF/ID register
- wb_en, mem_r_en, mem_w_en, b, s  out  1 each  registered control
- exe_cmd  out  4  registered ALU command
- pc, val_rn, val_rm  out  WORD_W  registered operands
- imm, shift_operand, signed_imm_24, dest, status  out  as inputs  registered fields

Behaviour:
- Reset values: all outputs 0; sequencer state IDLE.
- Sequencer has two states, IDLE and SORT2.
  - sort_cycle_count = (state==SORT2).
  - sort_stall = is_sort_in & (state==IDLE) & !flush. This is combinational, so the SORT stays in ID for a second cycle.
- Transitions, evaluated only when freeze=0:
  - IDLE → SORT2 when is_sort_in & !flush.
  - SORT2 → IDLE unconditionally.
  - flush forces IDLE.
- Register update priority: rst > freeze > flush > normal.
  - freeze=1: every output register and the state hold; sort_stall is still evaluated from the held state.
  - flush=1 (freeze=0): wb_en, mem_r_en, mem_w_en, b, s, exe_cmd load 0 and state goes to IDLE. Data fields load normally (don't-care).
  - Normal: all fields load from their *_in.
  - In SORT2, dest loads src2_in instead of dest_in: micro-op 0 (EXE_CMD 1110) writes Rd, micro-op 1 (EXE_CMD 1111) writes Rm.
- Latency: 1 cycle ID→EX for every instruction. SORT occupies EX for 2 consecutive cycles and injects 1 stall cycle upstream.
- Flush in SORT2 drops the second micro-op; no stall follows.
- Flush in IDLE with is_sort_in: no stall, SORT discarded.
- Freeze in SORT2 keeps sort_cycle_count=1 until freeze drops.
- rst mid-SORT aborts the sequence: next cycle state IDLE, count 0, outputs 0.
- Back-to-back SORTs: IDLE, SORT2, IDLE, SORT2, with stall on each IDLE cycle that has is_sort_in.

Optional Feature:
- Macro SORT_SEQ_EN.
- Defined: SORT sequencing exactly as above.
- Undefined: no state register; sort_cycle_count and sort_stall tied 0; is_sort_in ignored; dest always loads dest_in. The block is then a plain flushable/freezable pipeline register.

Test Plan:
- Reset, then ADD (wb_en_in=1, exe_cmd_in=0010, dest_in=3, pc_in=0x10) → next edge: wb_en=1, exe_cmd=0010, dest=3, pc=0x10; sort_stall never 1.
- SORT (dest_in=1, src2_in=2) held in ID 2 cycles:
  - Cycle 0: sort_stall=1, sort_cycle_count=0; after edge exe_cmd=1110, dest=1.
  - Cycle 1: count=1, stall=0; after edge exe_cmd=1111, dest=2.
  - Then IDLE.
- SORT then flush=1 during SORT2 → after edge exe_cmd=0, wb_en=0, state IDLE, count=0, no further stall.
- freeze=1 for 3 cycles in SORT2 with inputs changing → outputs and count=1 held for all 3 cycles; after release, second micro-op latched once.
- freeze=1 and flush=1 together with MEM_R_EN bundle already latched → bundle held (mem_r_en stays 1); flush=1 alone on next cycle → control zeroed.
- rst=1 asserted in SORT2 → next edge: all outputs 0, sort_cycle_count=0, sort_stall follows is_sort_in from IDLE.
